// File: rtl/gf180mcu_ws_io_pkg.sv
// Shared types and defaults for the gf180mcu_ws_io pad-ring power sequencer.
// Holds the sequencer state encoding and the output decode used by the top.
package gf180mcu_ws_io_pkg;

    localparam int unsigned DEB_CYCLES_DEF = 16;
    localparam int unsigned IO_DELAY_DEF   = 8;

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_CORE_UP  = 3'd2,
        ST_ON       = 3'd3,
        ST_DOWN     = 3'd4
    } pwr_state_e;

    typedef struct packed {
        logic core_rstn;
        logic io_oe_en;
        logic io_ie_en;
        logic ready;
    } pwr_outs_t;

    // DOWN keeps the core out of reset for one cycle after the pad gates close.
    function automatic pwr_outs_t decode_outs(input pwr_state_e state);
        pwr_outs_t outs;
        outs = '0;
        case (state)
            ST_CORE_UP: begin
                outs.core_rstn = 1'b1;
                outs.io_ie_en  = 1'b1;
            end
            ST_ON: begin
                outs.core_rstn = 1'b1;
                outs.io_ie_en  = 1'b1;
                outs.io_oe_en  = 1'b1;
                outs.ready     = 1'b1;
            end
            ST_DOWN: outs.core_rstn = 1'b1;
            default: outs = '0;
        endcase
        return outs;
    endfunction

endpackage

// File: rtl/gf180mcu_ws_io__sync2.sv
// Two-flop synchroniser for an asynchronous level input, reset to 0.
module gf180mcu_ws_io__sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // NOTE: non-blocking so the second stage samples the first stage's pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/gf180mcu_ws_io__pwr_seq.sv
// Power-up/power-down sequencer for the gf180mcu_ws_io pad ring.
// Optional brownout counter: define GF180MCU_WS_IO_PWR_SEQ_BROWNOUT_EN to build it.
module gf180mcu_ws_io__pwr_seq
    import gf180mcu_ws_io_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int unsigned IO_DELAY   = IO_DELAY_DEF,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned BO_W       = 8
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic            PG_DVDD,
    input  logic            PG_VDD,
    output logic            CORE_RSTN,
    output logic            IO_OE_EN,
    output logic            IO_IE_EN,
    output logic            READY,
    output logic [BO_W-1:0] BO_CNT
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] IO_LAST  = CNT_W'(IO_DELAY - 1);

    logic       pg_dvdd_s;
    logic       pg_vdd_s;
    logic       pg;
    pwr_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    pwr_outs_t  outs;

    gf180mcu_ws_io__sync2 u_sync_dvdd (
        .clk   (CLK),
        .rst_n (RSTN),
        .d     (PG_DVDD),
        .q     (pg_dvdd_s)
    );

    gf180mcu_ws_io__sync2 u_sync_vdd (
        .clk   (CLK),
        .rst_n (RSTN),
        .d     (PG_VDD),
        .q     (pg_vdd_s)
    );

    assign pg = pg_dvdd_s & pg_vdd_s;

    // NOTE: hold-current defaults first so no path through this block infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_OFF: begin
                if (pg) begin
                    state_d = ST_DEBOUNCE;
                    cnt_d   = '0;
                end
            end
            ST_DEBOUNCE: begin
                if (!pg) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_CORE_UP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CORE_UP: begin
                // Supply loss outranks the terminal count.
                if (!pg) begin
                    state_d = ST_DOWN;
                    cnt_d   = '0;
                end else if (cnt_q == IO_LAST) begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ON: begin
                if (!pg) begin
                    state_d = ST_DOWN;
                end
            end
            ST_DOWN: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: async reset clears every flop here; nothing in this block is a memory.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign outs      = decode_outs(state_q);
    assign CORE_RSTN = outs.core_rstn;
    assign IO_OE_EN  = outs.io_oe_en;
    assign IO_IE_EN  = outs.io_ie_en;
    assign READY     = outs.ready;

`ifdef GF180MCU_WS_IO_PWR_SEQ_BROWNOUT_EN
    logic [BO_W-1:0] bo_cnt_q, bo_cnt_d;

    always_comb begin
        bo_cnt_d = bo_cnt_q;
        if (state_d == ST_DOWN && state_q != ST_DOWN && bo_cnt_q != '1) begin
            bo_cnt_d = bo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            bo_cnt_q <= '0;
        end else begin
            bo_cnt_q <= bo_cnt_d;
        end
    end

    assign BO_CNT = bo_cnt_q;
`else
    assign BO_CNT = '0;
`endif

`ifndef SYNTHESIS
    if (DEB_CYCLES < 1 || IO_DELAY < 1) begin : g_bad_delay
        $error("DEB_CYCLES and IO_DELAY must both be at least 1");
    end
    if (CNT_W < 32 && (DEB_CYCLES > (1 << CNT_W) || IO_DELAY > (1 << CNT_W))) begin : g_bad_cnt_w
        $error("CNT_W too narrow for DEB_CYCLES/IO_DELAY");
    end

    // Pads may only drive while the core is out of reset.
    a_oe_needs_core : assert property (@(posedge CLK) disable iff (!RSTN)
        IO_OE_EN |-> CORE_RSTN);
    a_oe_before_rst : assert property (@(posedge CLK) disable iff (!RSTN)
        $fell(CORE_RSTN) |-> $past(!IO_OE_EN));
`endif

endmodule

// File: tb/tb_gf180mcu_ws_io__pwr_seq.sv
// Scoreboard bench for gf180mcu_ws_io__pwr_seq with DEB_CYCLES=4, IO_DELAY=3, BO_W=8.
module tb_gf180mcu_ws_io__pwr_seq;

`ifdef GF180MCU_WS_IO_PWR_SEQ_BROWNOUT_EN
    localparam bit BO_EN = 1'b1;
`else
    localparam bit BO_EN = 1'b0;
`endif

    typedef struct {
        int         cyc;
        logic [11:0] vec;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic       pg_dvdd;
    logic       pg_vdd;
    logic       core_rstn;
    logic       io_oe_en;
    logic       io_ie_en;
    logic       ready;
    logic [7:0] bo_cnt;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   bo_exp = 0;
    exp_t exp_q[$];

    gf180mcu_ws_io__pwr_seq #(
        .DEB_CYCLES (4),
        .IO_DELAY   (3),
        .CNT_W      (16),
        .BO_W       (8)
    ) dut (
        .CLK       (clk),
        .RSTN      (rstn),
        .PG_DVDD   (pg_dvdd),
        .PG_VDD    (pg_vdd),
        .CORE_RSTN (core_rstn),
        .IO_OE_EN  (io_oe_en),
        .IO_IE_EN  (io_ie_en),
        .READY     (ready),
        .BO_CNT    (bo_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [11:0] mk(input logic c, input logic ie, input logic oe,
                                       input logic rdy, input int bo);
        logic [7:0] b;
        b = bo[7:0];
        return {c, ie, oe, rdy, b};
    endfunction

    function automatic logic [11:0] sample();
        return {core_rstn, io_ie_en, io_oe_en, ready, bo_cnt};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int c, input logic [11:0] v);
        exp_t e;
        e.cyc = c;
        e.vec = v;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bo_bump();
        if (BO_EN && bo_exp < 255) bo_exp++;
    endtask

    // Raise whichever PG inputs are low; full sequence to ON.
    task automatic power_up();
        int t0;
        t0 = cyc;
        pg_dvdd = 1'b1;
        pg_vdd  = 1'b1;
        push(t0 + 7,  mk(1, 1, 0, 0, bo_exp));
        push(t0 + 10, mk(1, 1, 1, 1, bo_exp));
        tick(11);
    endtask

    // From ON: drop one or both supplies and expect the DOWN/OFF pair.
    task automatic power_down(input bit drop_vdd);
        int t0;
        t0 = cyc;
        pg_dvdd = 1'b0;
        if (drop_vdd) pg_vdd = 1'b0;
        bo_bump();
        push(t0 + 3, mk(1, 0, 0, 0, bo_exp));
        push(t0 + 4, mk(0, 0, 0, 0, bo_exp));
        tick(5);
    endtask

    // Monitor: every output change must match the head of the queue, value and edge.
    initial begin
        logic [11:0] prev, cur;
        exp_t e;
        @(negedge clk);
        prev = sample();
        forever begin
            @(negedge clk);
            cur = sample();
            if (cur !== prev) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_change: got 0x%0h, expected no change (edge %0d)",
                             cur, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("change_edge", cyc, e.cyc);
                    check("change_value", {20'd0, cur}, {20'd0, e.vec});
                end
            end
            prev = cur;
        end
    end

    initial begin
        int t0;
        rstn    = 1'b0;
        pg_dvdd = 1'b0;
        pg_vdd  = 1'b0;
        tick(3);
        check("reset_outs", {20'd0, sample()}, 32'd0);
        rstn = 1'b1;
        tick(3);
        check("off_idle", {20'd0, sample()}, 32'd0);

        // Clean power-up: CORE_RSTN/IE at +7, OE/READY at +10.
        power_up();

        // Repeated brownouts from ON; count saturates at 255.
        for (int i = 0; i < 300; i++) begin
            power_down(1'b0);
            power_up();
        end
        check("bo_saturated", {24'd0, bo_cnt}, BO_EN ? 32'd255 : 32'd0);
        power_down(1'b1);

        // One-cycle PG_VDD glitch during debounce restarts from OFF.
        t0 = cyc;
        pg_dvdd = 1'b1;
        pg_vdd  = 1'b1;
        tick(4);
        pg_vdd = 1'b0;
        tick(1);
        pg_vdd = 1'b1;
        push(t0 + 12, mk(1, 1, 0, 0, bo_exp));
        push(t0 + 15, mk(1, 1, 1, 1, bo_exp));
        tick(11);
        power_down(1'b1);

        // Supply loss on the CORE_UP terminal-count cycle goes to DOWN, never ON.
        t0 = cyc;
        pg_dvdd = 1'b1;
        pg_vdd  = 1'b1;
        push(t0 + 7, mk(1, 1, 0, 0, bo_exp));
        tick(7);
        pg_vdd = 1'b0;
        bo_bump();
        push(t0 + 10, mk(1, 0, 0, 0, bo_exp));
        push(t0 + 11, mk(0, 0, 0, 0, bo_exp));
        tick(6);

        // Asynchronous reset while ON, then restart with PG held high.
        power_up();
        #2;
        push(cyc, mk(0, 0, 0, 0, 0));
        rstn = 1'b0;
        #1;
        check("async_reset_outs", {20'd0, sample()}, 32'd0);
        bo_exp = 0;
        tick(2);
        t0 = cyc;
        rstn = 1'b1;
        push(t0 + 7,  mk(1, 1, 0, 0, bo_exp));
        push(t0 + 10, mk(1, 1, 1, 1, bo_exp));
        tick(11);
        check("ready_after_reset", {31'd0, ready}, 32'd1);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(1);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
